// File: rtl/audio_packet_scheduler.sv
// audio_packet_scheduler: buffers stereo samples and answers each hdmi packet_enable
// with the next data-island packet type (ACR, audio InfoFrame, audio sample or null).
module audio_packet_scheduler #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                           clk_pixel,
    input  logic                           reset_n,
    input  logic [9:0]                     cx,
    input  logic [9:0]                     cy,
    input  logic                           packet_enable,
    input  logic                           sample_valid,
    output logic                           sample_ready,
    input  logic [AUDIO_BIT_WIDTH-1:0]     sample_left,
    input  logic [AUDIO_BIT_WIDTH-1:0]     sample_right,
    output logic [7:0]                     packet_type,
    output logic [AUDIO_BIT_WIDTH-1:0]     audio_sample_word_left,
    output logic [AUDIO_BIT_WIDTH-1:0]     audio_sample_word_right,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
    localparam int W  = AUDIO_BIT_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {SEND_ACR, SEND_INFO, STREAM} state_t;

    state_t              state_q, state_d;
    logic [7:0]          type_q, type_d;
    logic [W-1:0]        word_l_q, word_l_d, word_r_q, word_r_d;
    logic [2*W-1:0]      mem_q [FIFO_DEPTH];
    logic [2*W-1:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                frame_start, wr_en, pop;

    assign frame_start  = (cx == 10'd0) && (cy == 10'd0);
    assign sample_ready = level_q != LW'(FIFO_DEPTH);
    assign wr_en        = sample_valid && sample_ready;
    // Pop only sees entries already registered, so a same-cycle write into an empty FIFO yields null.
    assign pop          = packet_enable && !frame_start && (state_q == STREAM) && (level_q != '0);

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        word_l_d = word_l_q;
        word_r_d = word_r_q;
        if (frame_start) begin
            state_d = packet_enable ? SEND_INFO : SEND_ACR;
            type_d  = packet_enable ? 8'h01 : type_q;
        end else if (packet_enable) begin
            if (state_q == SEND_ACR) begin
                type_d  = 8'h01;
                state_d = SEND_INFO;
            end else if (state_q == SEND_INFO) begin
                type_d  = 8'h84;
                state_d = STREAM;
            end else begin
                type_d = pop ? 8'h02 : 8'h00;
                if (pop) {word_l_d, word_r_d} = mem_q[rptr_q];
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wptr_q] = {sample_left, sample_right};
        wptr_d  = wptr_q + PW'(wr_en);
        rptr_d  = rptr_q + PW'(pop);
        level_d = level_q + LW'(wr_en) - LW'(pop);
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SEND_ACR;
            type_q   <= 8'h00;
            word_l_q <= '0;
            word_r_q <= '0;
            mem_q    <= '{default: '0};
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            word_l_q <= word_l_d;
            word_r_q <= word_r_d;
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
        end
    end

    assign packet_type             = type_q;
    assign audio_sample_word_left  = word_l_q;
    assign audio_sample_word_right = word_r_q;
    assign fifo_level              = level_q;
endmodule
